// File: rtl/add_seq_ctrl_pkg.sv
// add_seq_ctrl_pkg: shared state and opcode encodings for the multi-byte add/sub sequencer
package add_seq_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/add_seq_ctrl_adder8.sv
// adder8: 8-bit ripple-carry adder datapath
module adder8 (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       cin_i,
  output logic [7:0] sum_o,
  output logic       cout_o
);
  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {8'd0, cin_i};
endmodule

// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: byte-serial NBYTES-wide add/subtract around a single adder8
module add_seq_ctrl
  import add_seq_ctrl_pkg::*;
#(
  parameter int NBYTES = 4,
  localparam int W = 8 * NBYTES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         op_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);
  localparam int CW = $clog2(NBYTES + 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
  logic [7:0] add_s;
  logic add_c;
  logic [W+7:0] res_cat;
  logic [W-1:0] res_nx;
  logic last;
  adder8 u_adder (
    .a_i   (a_q[7:0]),
    .b_i   (b_q[7:0]),
    .cin_i (carry_q),
    .sum_o (add_s),
    .cout_o(add_c)
  );
  assign res_cat   = {add_s, res_q} >> 8;
  assign res_nx    = res_cat[W-1:0];
  assign last      = cnt_q == CW'(NBYTES - 1);
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  // next state: accept in IDLE, one byte per RUN cycle LSB first, hold results in DONE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d     = op_a;
        b_d     = (op_sub == OP_SUB) ? ~op_b : op_b;
        carry_d = op_sub;
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        res_d   = res_nx;
        carry_d = add_c;
        a_d     = a_q >> 8;
        b_d     = b_q >> 8;
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          sum_d   = res_nx;
          cout_d  = add_c;
          ovf_d   = (a_q[7] == b_q[7]) && (add_s[7] != a_q[7]);
          zero_d  = res_nx == '0;
          state_d = DONE;
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers with synchronous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end
endmodule
